// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: pixel-coordinate -> colour bus between the timing generator and graphics/encoder side
//   master (timing generator): drives pos_x, pos_y, active, frame_start, vid_rgb, vid_de, vid_hsync, vid_vsync; samples rgb_in
//   slave  (graphics + TMDS front end): supplies rgb_in combinationally from pos_x/pos_y, consumes vid_*
interface video_timing_gen_if;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        active;
  logic        frame_start;
  logic [23:0] rgb_in;
  logic [23:0] vid_rgb;
  logic        vid_de;
  logic        vid_hsync;
  logic        vid_vsync;
  modport master (
    output pos_x, pos_y, active, frame_start, vid_rgb, vid_de, vid_hsync, vid_vsync,
    input  rgb_in
  );
  modport slave (
    input  pos_x, pos_y, active, frame_start, vid_rgb, vid_de, vid_hsync, vid_vsync,
    output rgb_in
  );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: 640x480@60 raster timing, pixel coordinates out, colour re-registered with de/hsync/vsync
//   clk, rst_n (async active-low), enable (counters and both stages advance only when high)
//   vid (video_timing_gen_if.master): pos_x/pos_y/active/frame_start (stage 0), rgb_in (comb. colour back),
//     vid_rgb/vid_de/vid_hsync/vid_vsync (stage 1, one clock after pos)
//   VIDEO_TIMING_TEST_PATTERN_EN: adds test_mode input selecting 8 vertical colour bars instead of rgb_in
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input logic clk,
  input logic rst_n,
  input logic enable,
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  input logic test_mode,
`endif
  video_timing_gen_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("video_timing_gen: H_TOTAL and V_TOTAL must fit 10-bit counters");
  end
  typedef enum logic [1:0] {ACT, FP, SYN, BP} phase_t;
  logic [9:0]  h_cnt, v_cnt, h_nxt, v_nxt;
  phase_t      h_st, h_st_nxt, v_st, v_st_nxt;
  logic        h_wrap, v_wrap, vis, hs_raw, vs_raw;
  logic [23:0] pix;
  // The phase registers always describe the current h_cnt/v_cnt; each
  // transition fires on the last count of its phase. Vertical phases move
  // only on the horizontal wrap edge, so the 799/524 corner wraps both at once.
  always_comb begin
    h_wrap = h_cnt == 10'(H_TOTAL - 1);
    v_wrap = v_cnt == 10'(V_TOTAL - 1);
    h_nxt = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_nxt = h_wrap ? (v_wrap ? 10'd0 : v_cnt + 10'd1) : v_cnt;
    vis = h_st == ACT && v_st == ACT;
    h_st_nxt = h_st;
    case (h_st)
      ACT: h_st_nxt = h_cnt == 10'(H_ACTIVE - 1) ? FP : ACT;
      FP:  h_st_nxt = h_cnt == 10'(H_ACTIVE + H_FP - 1) ? SYN : FP;
      SYN: h_st_nxt = h_cnt == 10'(H_ACTIVE + H_FP + H_SYNC - 1) ? BP : SYN;
      BP:  h_st_nxt = h_wrap ? ACT : BP;
      default: h_st_nxt = ACT;
    endcase
    v_st_nxt = v_st;
    if (h_wrap)
      case (v_st)
        ACT: v_st_nxt = v_cnt == 10'(V_ACTIVE - 1) ? FP : ACT;
        FP:  v_st_nxt = v_cnt == 10'(V_ACTIVE + V_FP - 1) ? SYN : FP;
        SYN: v_st_nxt = v_cnt == 10'(V_ACTIVE + V_FP + V_SYNC - 1) ? BP : SYN;
        BP:  v_st_nxt = v_wrap ? ACT : BP;
        default: v_st_nxt = ACT;
      endcase
  end
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  logic [2:0] bar;
  // Bars in order white, yellow, cyan, green, magenta, red, blue, black:
  // red is off for bars 2,3,6,7, green for 4..7, blue for odd bars.
  always_comb begin
    bar = 3'(vid.pos_x / 10'd80);
    pix = test_mode ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : vid.rgb_in;
  end
`else
  assign pix = vid.rgb_in;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
      h_st <= ACT;
      v_st <= ACT;
      vid.pos_x <= '0;
      vid.pos_y <= '0;
      vid.active <= 1'b0;
      vid.frame_start <= 1'b0;
      hs_raw <= 1'b0;
      vs_raw <= 1'b0;
    end else if (enable) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      h_st <= h_st_nxt;
      v_st <= v_st_nxt;
      vid.pos_x <= vis ? h_cnt : 10'd0;
      vid.pos_y <= vis ? v_cnt : 10'd0;
      vid.active <= vis;
      vid.frame_start <= h_cnt == 10'd0 && v_cnt == 10'd0;
      hs_raw <= h_st == SYN;
      vs_raw <= v_st == SYN;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.vid_rgb <= '0;
      vid.vid_de <= 1'b0;
      vid.vid_hsync <= !SYNC_POL;
      vid.vid_vsync <= !SYNC_POL;
    end else if (enable) begin
      vid.vid_rgb <= vid.active ? pix : 24'h0;
      vid.vid_de <= vid.active;
      vid.vid_hsync <= hs_raw ? SYNC_POL : !SYNC_POL;
      vid.vid_vsync <= vs_raw ? SYNC_POL : !SYNC_POL;
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed table + corner sequences for video_timing_gen (full 800-clock lines, 30-line frames)
module tb_video_timing_gen;
  localparam int VA = 20, VF = 3, VS = 2, VB = 5;
  localparam int FRAME = 800 * (VA + VF + VS + VB);
  localparam logic [48:0] RST_VAL = {10'd0, 10'd0, 3'b000, 2'b11, 24'h0};
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1;
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  logic test_mode = 1'b0;
`endif
  int checks = 0, failures = 0, cyc = 0;
  video_timing_gen_if vif();
  assign vif.rgb_in = {vif.pos_x[7:0], vif.pos_y[7:0], 8'hA5};
  video_timing_gen #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .vid(vif)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  typedef struct {
    int t, px, py, act, fs, de, hs, vs;
    logic [23:0] rgb;
  } vec_t;
  vec_t vt[20];
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  function automatic logic [48:0] snap();
    return {vif.pos_x, vif.pos_y, vif.active, vif.frame_start, vif.vid_de,
            vif.vid_hsync, vif.vid_vsync, vif.vid_rgb};
  endfunction
  task automatic wait_pos(input logic [9:0] x, input logic [9:0] y, input string nm);
    for (int i = 0; i < 2 * FRAME && !(vif.pos_x == x && vif.pos_y == y); i++) @(negedge clk);
    chk(nm, {vif.pos_x, vif.pos_y}, {x, y});
  endtask
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  function automatic logic [23:0] bar_rgb(input logic [9:0] x);
    case (x / 80)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction
`endif
  initial begin
    int k, fs_cyc, de_run, de_lines, bad_de, hs_run, hs_pulses, bad_hs, vs_low, vs_pulses, fs_cnt, rgb_err, hold_err;
    logic de_p, hs_p, vs_p, prev_act;
    logic [9:0] prev_px, prev_py;
    logic [23:0] exp_rgb;
    logic [48:0] s;
    // t = posedges since reset release; stage 0 shows counter t-1, stage 1 shows counter t-2
    vt = '{
      '{1,     0,   0,  1, 1, 0, 1, 1, 24'h0},
      '{2,     1,   0,  1, 0, 1, 1, 1, 24'h0000A5},
      '{3,     2,   0,  1, 0, 1, 1, 1, 24'h0100A5},
      '{640,   639, 0,  1, 0, 1, 1, 1, 24'h7E00A5},
      '{641,   0,   0,  0, 0, 1, 1, 1, 24'h7F00A5},
      '{642,   0,   0,  0, 0, 0, 1, 1, 24'h0},
      '{657,   0,   0,  0, 0, 0, 1, 1, 24'h0},
      '{658,   0,   0,  0, 0, 0, 0, 1, 24'h0},
      '{753,   0,   0,  0, 0, 0, 0, 1, 24'h0},
      '{754,   0,   0,  0, 0, 0, 1, 1, 24'h0},
      '{801,   0,   1,  1, 0, 0, 1, 1, 24'h0},
      '{802,   1,   1,  1, 0, 1, 1, 1, 24'h0001A5},
      '{15840, 639, 19, 1, 0, 1, 1, 1, 24'h7E13A5},
      '{15841, 0,   0,  0, 0, 1, 1, 1, 24'h7F13A5},
      '{16002, 0,   0,  0, 0, 0, 1, 1, 24'h0},
      '{18401, 0,   0,  0, 0, 0, 1, 1, 24'h0},
      '{18402, 0,   0,  0, 0, 0, 1, 0, 24'h0},
      '{20001, 0,   0,  0, 0, 0, 1, 0, 24'h0},
      '{20002, 0,   0,  0, 0, 0, 1, 1, 24'h0},
      '{24000, 0,   0,  0, 0, 0, 1, 1, 24'h0}
    };
    repeat (3) @(negedge clk);
    chk("reset_state", snap(), RST_VAL);
    rst_n = 1'b1;
    k = 0; fs_cyc = 0; de_run = 0; de_lines = 0; bad_de = 0; hs_run = 0; hs_pulses = 0; bad_hs = 0;
    vs_low = 0; vs_pulses = 0; fs_cnt = 0; rgb_err = 0;
    de_p = 1'b0; hs_p = 1'b1; vs_p = 1'b1; prev_act = 1'b0; prev_px = '0; prev_py = '0;
    for (int t = 1; t <= FRAME + 1; t++) begin
      @(negedge clk);
      if (k < 20 && vt[k].t == t) begin
        chk($sformatf("vec_t%0d", t), snap(),
            {10'(vt[k].px), 10'(vt[k].py), 1'(vt[k].act), 1'(vt[k].fs), 1'(vt[k].de),
             1'(vt[k].hs), 1'(vt[k].vs), vt[k].rgb});
        k++;
      end
      exp_rgb = prev_act ? {prev_px[7:0], prev_py[7:0], 8'hA5} : 24'h0;
      if (vif.vid_rgb !== exp_rgb || vif.vid_de !== prev_act) rgb_err++;
      prev_act = vif.active; prev_px = vif.pos_x; prev_py = vif.pos_y;
      if (vif.vid_de) de_run++;
      if (!vif.vid_de && de_p) begin de_lines++; if (de_run != 640) bad_de++; de_run = 0; end
      if (!vif.vid_hsync) hs_run++;
      if (vif.vid_hsync && !hs_p) begin hs_pulses++; if (hs_run != 96) bad_hs++; hs_run = 0; end
      if (!vif.vid_vsync) vs_low++;
      if (!vif.vid_vsync && vs_p) vs_pulses++;
      if (vif.frame_start) begin fs_cnt++; fs_cyc = cyc; end
      de_p = vif.vid_de; hs_p = vif.vid_hsync; vs_p = vif.vid_vsync;
    end
    chk("frame2_start", snap(), {10'd0, 10'd0, 3'b110, 2'b11, 24'h0});
    chk("table_done", 64'(k), 64'd20);
    chk("de_lines", 64'(de_lines), 64'(VA));
    chk("de_run_len_bad", 64'(bad_de), 64'd0);
    chk("hs_pulses", 64'(hs_pulses), 64'(VA + VF + VS + VB));
    chk("hs_len_bad", 64'(bad_hs), 64'd0);
    chk("vs_low_clocks", 64'(vs_low), 64'(800 * VS));
    chk("vs_pulses", 64'(vs_pulses), 64'd1);
    chk("fs_count", 64'(fs_cnt), 64'd2);
    chk("rgb_track_err", 64'(rgb_err), 64'd0);
    wait_pos(10'd100, 10'd10, "pause_pos");
    s = snap();
    enable = 1'b0;
    hold_err = 0;
    repeat (37) begin
      @(negedge clk);
      if (snap() !== s) hold_err++;
    end
    chk("hold_err", 64'(hold_err), 64'd0);
    enable = 1'b1;
    @(negedge clk);
    chk("resume_pos", {vif.pos_x, vif.pos_y}, {10'd101, 10'd10});
    for (int i = 0; i < 2 * FRAME && !vif.frame_start; i++) @(negedge clk);
    chk("frame_len_paused", 64'(cyc - fs_cyc), 64'(FRAME + 37));
    wait_pos(10'd300, 10'd15, "reset_pos");
    #2 rst_n = 1'b0;
    #1 chk("async_reset", snap(), RST_VAL);
    repeat (2) @(negedge clk);
    chk("reset_hold", snap(), RST_VAL);
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_rst_1", snap(), {10'd0, 10'd0, 3'b110, 2'b11, 24'h0});
    @(negedge clk);
    chk("after_rst_2", snap(), {10'd1, 10'd0, 3'b101, 2'b11, 24'h0000A5});
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    begin
      int pat_err;
      logic [23:0] got0, got80, got639;
      pat_err = 0; got0 = 'x; got80 = 'x; got639 = 'x;
      prev_act = vif.active; prev_px = vif.pos_x;
      test_mode = 1'b1;
      for (int i = 0; i < 1700; i++) begin
        @(negedge clk);
        if (vif.vid_rgb !== (prev_act ? bar_rgb(prev_px) : 24'h0)) pat_err++;
        if (prev_act && prev_px == 10'd0) got0 = vif.vid_rgb;
        if (prev_act && prev_px == 10'd80) got80 = vif.vid_rgb;
        if (prev_act && prev_px == 10'd639) got639 = vif.vid_rgb;
        prev_act = vif.active; prev_px = vif.pos_x;
      end
      chk("pat_err", 64'(pat_err), 64'd0);
      chk("pat_x0", 64'(got0), 64'hFFFFFF);
      chk("pat_x80", 64'(got80), 64'hFFFF00);
      chk("pat_x639", 64'(got639), 64'h000000);
      test_mode = 1'b0;
      wait_pos(10'd5, 10'd3, "pat_off_pos");
      @(negedge clk);
      chk("pat_off_rgb", 64'(vif.vid_rgb), 64'h0503A5);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
